// File: rtl/cache_pkg.sv
// Shared cache types and defaults used by cache_line and its controller.
package cache_pkg;

  localparam int LSB_BITS_DEF = 7;
  localparam int TTL_BITS_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_FLUSH,
    S_WAITF,
    S_FILL,
    S_WAITL,
    S_DONE
  } state_t;

  function automatic logic [63:0] region_mask(
    input int unsigned lsb
  );
    return ~((64'd1 << lsb) - 64'd1);
  endfunction

endpackage

// File: rtl/ttl_min_select.sv
// Argmin over the packed line TTLs; ties resolve to the lowest index.
module ttl_min_select #(
  parameter int NUMLINES    = 4,
  parameter int LINEIDXBITS = 2,
  parameter int TTLBITS     = 8
) (
  input  logic [NUMLINES*TTLBITS-1:0] ttl,
  output logic [LINEIDXBITS-1:0]      idx
);

  logic [TTLBITS-1:0] best;

  always_comb begin
    best = ttl[0 +: TTLBITS];
    idx  = '0;
    for (int i = 1; i < NUMLINES; i++) begin
      if (ttl[i*TTLBITS +: TTLBITS] < best) begin
        best = ttl[i*TTLBITS +: TTLBITS];
        idx  = LINEIDXBITS'(i);
      end
    end
  end

endmodule

// File: rtl/cache_line_ctrl.sv
// Victim selection, flush and refill sequencing for a bank of cache lines.
module cache_line_ctrl
  import cache_pkg::*;
#(
  parameter int NUMLINES    = 4,
  parameter int LINEIDXBITS = 2,
  parameter int ADDRBITS    = 32,
  parameter int LSBBITS     = LSB_BITS_DEF,
  parameter int TTLBITS     = TTL_BITS_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        dcache_rdreq,
  input  logic                        dcache_wrreq,
  input  logic [ADDRBITS-1:0]         dcache_addr,
  input  logic                        icache_rdreq,
  input  logic [ADDRBITS-1:0]         icache_addr,
  input  logic [NUMLINES-1:0]         line_miss,
  input  logic [NUMLINES-1:0]         line_dirty,
  input  logic [NUMLINES-1:0]         line_ready,
  input  logic [NUMLINES*TTLBITS-1:0] line_ttl,
  input  logic                        mem_busy,
  output logic [NUMLINES-1:0]         line_flush,
  output logic [NUMLINES-1:0]         line_fill,
  output logic                        line_pause,
  output logic [ADDRBITS-1:0]         cache_new_region,
  output logic                        core_stall
);

  localparam logic [ADDRBITS-1:0] RMASK =
    ADDRBITS'(region_mask(LSBBITS));

  state_t                 state;
  logic [LINEIDXBITS-1:0] victim;
  logic [LINEIDXBITS-1:0] min_idx;
  logic [ADDRBITS-1:0]    miss_addr;
  logic                   wait_skip;

  logic                   dreq;
  logic                   allmiss;
  logic [ADDRBITS-1:0]    req_addr;
  logic [NUMLINES-1:0]    victim_oh;

  ttl_min_select #(
    .NUMLINES    (NUMLINES),
    .LINEIDXBITS (LINEIDXBITS),
    .TTLBITS     (TTLBITS)
  ) u_min (
    .ttl (line_ttl),
    .idx (min_idx)
  );

  assign dreq     = dcache_rdreq | dcache_wrreq;
  assign allmiss  = (&line_miss) & (dreq | icache_rdreq);
  assign req_addr = dreq ? dcache_addr : icache_addr;

  assign victim_oh  = NUMLINES'(1) << victim;
  assign line_pause = mem_busy;
  assign core_stall = (state != S_IDLE) | allmiss;

  // Pulses are held off while memory is busy; the FSM waits with them.
  assign line_flush =
    (state == S_FLUSH && !mem_busy) ? victim_oh : '0;
  assign line_fill =
    (state == S_FILL && !mem_busy) ? victim_oh : '0;
  assign cache_new_region =
    (state == S_FILL || state == S_WAITL) ? miss_addr : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      victim    <= '0;
      miss_addr <= '0;
      wait_skip <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (allmiss) begin
            miss_addr <= req_addr & RMASK;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          victim <= min_idx;
          state  <= line_dirty[min_idx] ? S_FLUSH : S_FILL;
        end
        S_FLUSH: begin
          if (!mem_busy) begin
            wait_skip <= 1'b1;
            state     <= S_WAITF;
          end
        end
        S_WAITF: begin
          // Ready is stale on the first cycle after the pulse.
          if (wait_skip) wait_skip <= 1'b0;
          else if (line_ready[victim]) state <= S_FILL;
        end
        S_FILL: begin
          if (!mem_busy) begin
            wait_skip <= 1'b1;
            state     <= S_WAITL;
          end
        end
        S_WAITL: begin
          if (wait_skip) wait_skip <= 1'b0;
          else if (line_ready[victim]) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed bench for cache_line_ctrl: vector table plus corner sequences.
module tb_cache_line_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dcache_rdreq, dcache_wrreq, icache_rdreq;
  logic [31:0] dcache_addr, icache_addr;
  logic [3:0]  line_miss, line_dirty, line_ready;
  logic [31:0] line_ttl;
  logic        mem_busy;
  logic [3:0]  line_flush, line_fill;
  logic        line_pause;
  logic [31:0] cache_new_region;
  logic        core_stall;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] T2  = {8'd70, 8'd90, 8'd10, 8'd40};
  localparam logic [31:0] TFF = 32'hFFFF_FFFF;

  cache_line_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .dcache_rdreq     (dcache_rdreq),
    .dcache_wrreq     (dcache_wrreq),
    .dcache_addr      (dcache_addr),
    .icache_rdreq     (icache_rdreq),
    .icache_addr      (icache_addr),
    .line_miss        (line_miss),
    .line_dirty       (line_dirty),
    .line_ready       (line_ready),
    .line_ttl         (line_ttl),
    .mem_busy         (mem_busy),
    .line_flush       (line_flush),
    .line_fill        (line_fill),
    .line_pause       (line_pause),
    .cache_new_region (cache_new_region),
    .core_stall       (core_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dr, dw, ir;
    logic [31:0] da, ia;
    logic [3:0]  miss, dirty, ready;
    logic [31:0] ttl;
    logic        busy;
    logic [3:0]  e_flush, e_fill;
    logic        e_pause;
    logic [31:0] e_region;
    logic        e_stall;
  } vec_t;

  vec_t vt[10];

  function automatic vec_t mk(
    logic dr, logic dw, logic ir, logic [31:0] da,
    logic [3:0] miss, logic busy,
    logic [3:0] e_flush, logic [3:0] e_fill, logic e_pause,
    logic [31:0] e_region, logic e_stall
  );
    vec_t v;
    v.dr = dr; v.dw = dw; v.ir = ir;
    v.da = da; v.ia = 32'h0;
    v.miss = miss; v.dirty = 4'b0000; v.ready = 4'b1111;
    v.ttl = T2; v.busy = busy;
    v.e_flush = e_flush; v.e_fill = e_fill; v.e_pause = e_pause;
    v.e_region = e_region; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(vec_t v);
    dcache_rdreq = v.dr; dcache_wrreq = v.dw; icache_rdreq = v.ir;
    dcache_addr = v.da; icache_addr = v.ia;
    line_miss = v.miss; line_dirty = v.dirty; line_ready = v.ready;
    line_ttl = v.ttl; mem_busy = v.busy;
  endtask

  task automatic wait_fill(string name, int bound,
                           logic [3:0] mask, logic [31:0] region);
    bit found = 0;
    for (int k = 0; k < bound && !found; k++) begin
      #2;
      if (line_fill != 4'b0000) begin
        found = 1;
        chk({name, "_fill"}, {28'h0, line_fill}, {28'h0, mask});
        chk({name, "_region"}, cache_new_region, region);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no fill within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_idle(string name, int bound);
    bit found = 0;
    for (int k = 0; k < bound && !found; k++) begin
      #2;
      if (!core_stall) found = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL %s: stall still 1 after %0d cycles, want 0",
               name, bound);
    end
  endtask

  task automatic chk_zero(string name);
    chk({name, "_flush"}, {28'h0, line_flush}, 32'h0);
    chk({name, "_fill"}, {28'h0, line_fill}, 32'h0);
    chk({name, "_region"}, cache_new_region, 32'h0);
    chk({name, "_stall"}, {31'h0, core_stall}, 32'h0);
  endtask

  initial begin
    vt[0] = mk(1, 0, 0, 32'h1234, 4'b1011, 0, 0, 0, 0, 32'h0,    0);
    vt[1] = mk(1, 0, 0, 32'h1234, 4'b1111, 0, 0, 0, 0, 32'h0,    1);
    vt[2] = mk(0, 0, 0, 32'h0,    4'b1111, 0, 0, 0, 0, 32'h0,    1);
    vt[3] = mk(0, 0, 0, 32'h0,    4'b1111, 0, 0, 2, 0, 32'h1200, 1);
    vt[4] = mk(0, 0, 0, 32'h0,    4'b1111, 0, 0, 0, 0, 32'h1200, 1);
    vt[5] = mk(0, 0, 0, 32'h0,    4'b1111, 0, 0, 0, 0, 32'h1200, 1);
    vt[6] = mk(0, 0, 0, 32'h0,    4'b1111, 0, 0, 0, 0, 32'h0,    1);
    vt[7] = mk(0, 0, 0, 32'h0,    4'b1111, 0, 0, 0, 0, 32'h0,    0);
    vt[8] = mk(0, 0, 0, 32'h0,    4'b1111, 1, 0, 0, 1, 32'h0,    0);
    vt[9] = mk(0, 1, 0, 32'h40,   4'b0111, 0, 0, 0, 0, 32'h0,    0);

    reset = 1'b1;
    drive(mk(0, 0, 0, 32'h0, 4'b0000, 0, 0, 0, 0, 32'h0, 0));
    #12;
    chk_zero("reset");
    chk("reset_pause", {31'h0, line_pause}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vt[i]);
      #2;
      chk($sformatf("v%0d_flush", i), {28'h0, line_flush},
          {28'h0, vt[i].e_flush});
      chk($sformatf("v%0d_fill", i), {28'h0, line_fill},
          {28'h0, vt[i].e_fill});
      chk($sformatf("v%0d_pause", i), {31'h0, line_pause},
          {31'h0, vt[i].e_pause});
      chk($sformatf("v%0d_region", i), cache_new_region,
          vt[i].e_region);
      chk($sformatf("v%0d_stall", i), {31'h0, core_stall},
          {31'h0, vt[i].e_stall});
      tick();
    end

    // Dirty victim with slow ready after each pulse
    drive(mk(1, 0, 0, 32'h4321_00FF, 4'hF, 0, 0, 0, 0, 0, 0));
    line_dirty = 4'b0010;
    #2;
    chk("dirty_trig_stall", {31'h0, core_stall}, 32'h1);
    tick();
    dcache_rdreq = 1'b0;
    tick();
    #2;
    chk("dirty_flush", {28'h0, line_flush}, 32'h2);
    chk("dirty_noearlyfill", {28'h0, line_fill}, 32'h0);
    tick();
    line_ready = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk($sformatf("dirty_wf%0d_fill", k), {28'h0, line_fill}, 32'h0);
      chk($sformatf("dirty_wf%0d_flush", k), {28'h0, line_flush},
          32'h0);
      tick();
    end
    line_ready = 4'b1111;
    wait_fill("dirty", 4, 4'b0010, 32'h4321_0080);
    tick();
    line_ready = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk($sformatf("dirty_wl%0d_stall", k), {31'h0, core_stall},
          32'h1);
      tick();
    end
    line_ready = 4'b1111;
    line_dirty = 4'b0000;
    wait_idle("dirty_done", 6);
    tick();

    // Simultaneous dcache and icache misses
    drive(mk(1, 0, 1, 32'h100, 4'hF, 0, 0, 0, 0, 0, 0));
    icache_addr = 32'h2000;
    #2;
    chk("dual_stall", {31'h0, core_stall}, 32'h1);
    tick();
    dcache_rdreq = 1'b0;
    wait_fill("dual_d", 6, 4'b0010, 32'h100);
    tick();
    wait_fill("dual_i", 10, 4'b0010, 32'h2000);
    icache_rdreq = 1'b0;
    tick();
    wait_idle("dual_done", 6);
    tick();

    // All TTLs saturated, memory busy for three cycles
    drive(mk(1, 0, 0, 32'h0000_ABCD, 4'hF, 1, 0, 0, 0, 0, 0));
    line_ttl = TFF;
    #2;
    chk("busy_pause", {31'h0, line_pause}, 32'h1);
    tick();
    dcache_rdreq = 1'b0;
    tick();
    #2;
    chk("busy_fill_held", {28'h0, line_fill}, 32'h0);
    chk("busy_stall", {31'h0, core_stall}, 32'h1);
    tick();
    mem_busy = 1'b0;
    #2;
    chk("tie_fill", {28'h0, line_fill}, 32'h1);
    chk("tie_region", cache_new_region, 32'h0000_AB80);
    chk("tie_pause", {31'h0, line_pause}, 32'h0);
    tick();
    wait_idle("tie_done", 6);
    tick();

    // Reset in the middle of WAITL
    drive(mk(1, 0, 0, 32'h5555_5555, 4'hF, 0, 0, 0, 0, 0, 0));
    tick();
    dcache_rdreq = 1'b0;
    tick();
    tick();
    line_ready = 4'b1101;
    tick();
    #2;
    chk("rst_pre_region", cache_new_region, 32'h5555_5500);
    reset = 1'b1;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    line_ready = 4'b1111;
    #2;
    chk("rst_rel_stall", {31'h0, core_stall}, 32'h0);
    tick();
    chk_zero("rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
